// File: rtl/i2c_reg_bank_pkg.sv
// Shared address map and parameter limits for the I2C register bank.
package i2c_reg_pkg;

    localparam logic [7:0] ADDR_PAGE       = 8'h80;
    localparam logic [7:0] ADDR_CFG_BASE   = 8'h81;
    localparam logic [7:0] ADDR_CNT_BASE   = 8'hA0;
    localparam logic [7:0] ADDR_PULSE_BASE = 8'hF0;
    localparam logic [7:0] ADDR_VERSION    = 8'hFF;

    localparam int MAX_CFG   = 31;
    localparam int MAX_CNT   = 8;
    localparam int MAX_PULSE = 8;

endpackage

// File: rtl/i2c_reg_bank_pulse_stretcher.sv
// Command pulse stretcher: a trigger (re)loads a down-counter, output is high while it is non-zero.
module pulse_stretcher #(
    parameter int LEN = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic trigger,
    output logic pulse
);

    logic [7:0] count_q, count_d;

    // Reload on trigger (retrigger extends), otherwise count down to terminal zero.
    always_comb begin
        count_d = count_q;
        if (trigger) begin
            count_d = 8'(LEN);
        end else if (count_q != 8'd0) begin
            count_d = count_q - 8'd1;
        end
    end

    // Counter register; reset truncates any pulse in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign pulse = (count_q != 8'd0);

endmodule

// File: rtl/i2c_reg_bank.sv
// I2C register bank: OSD RAM write window, config bytes, snapshot counters and command pulses.
module i2c_reg_bank
    import i2c_reg_pkg::*;
#(
    parameter int                 N_CFG     = 8,
    parameter logic [N_CFG*8-1:0] CFG_RESET = '0,
    parameter int                 N_CNT     = 6,
    parameter int                 N_PULSE   = 4,
    parameter int                 PULSE_LEN = 4,
    parameter int                 PAGE_W    = 3,
    parameter logic [7:0]         VERSION   = 8'h01
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            addr,
    input  logic [7:0]            dataIn,
    input  logic                  writeEn,
    input  logic                  readEn,
    output logic [7:0]            dataOut,
    output logic [7:0]            ram_dataIn,
    output logic [PAGE_W+6:0]     ram_wraddress,
    output logic                  ram_wren,
    output logic [N_CFG*8-1:0]    cfg_data,
    input  logic [N_CNT*32-1:0]   cnt_in,
    output logic [N_CNT-1:0]      cnt_clear,
    output logic [N_PULSE-1:0]    pulse_out
);

    if (N_CFG < 1 || N_CFG > MAX_CFG || N_CNT < 1 || N_CNT > MAX_CNT ||
        N_PULSE < 1 || N_PULSE > MAX_PULSE || PULSE_LEN < 1 || PULSE_LEN > 255 ||
        PAGE_W < 1 || PAGE_W > 8) begin : g_bad_param
        $error("i2c_reg_bank: parameter out of range");
    end

    logic [7:0]                 dout_q, dout_d;
    logic [PAGE_W-1:0]          page_q, page_d;
    logic [N_CFG-1:0][7:0]      cfg_q, cfg_d;
    logic [N_CNT-1:0][31:0]     shadow_q, shadow_d;
    logic [N_CNT-1:0]           clear_q, clear_d;
    logic                       wren_q, wren_d;
    logic [PAGE_W+6:0]          wraddr_q, wraddr_d;
    logic [N_PULSE-1:0]         pulse_trig;

    // Write decode and snapshot capture; a write to counter byte 0 overrides a same-cycle snapshot.
    always_comb begin
        page_d     = page_q;
        cfg_d      = cfg_q;
        shadow_d   = shadow_q;
        clear_d    = '0;
        wren_d     = 1'b0;
        wraddr_d   = wraddr_q;
        pulse_trig = '0;
        if (readEn) begin
            for (int k = 0; k < N_CNT; k++) begin
                if (addr == ADDR_CNT_BASE + 8'(4 * k)) shadow_d[k] = cnt_in[32*k +: 32];
            end
        end
        if (writeEn) begin
            if (!addr[7]) begin
                wren_d   = 1'b1;
                wraddr_d = {page_q, addr[6:0]};
            end
            if (addr == ADDR_PAGE) page_d = dataIn[PAGE_W-1:0];
            for (int i = 0; i < N_CFG; i++) begin
                if (addr == ADDR_CFG_BASE + 8'(i)) cfg_d[i] = dataIn;
            end
            for (int k = 0; k < N_CNT; k++) begin
                if (addr == ADDR_CNT_BASE + 8'(4 * k)) begin
                    clear_d[k]  = 1'b1;
                    shadow_d[k] = '0;
                end
            end
            for (int i = 0; i < N_PULSE; i++) begin
                if (addr == ADDR_PULSE_BASE + 8'(i)) pulse_trig[i] = 1'b1;
            end
        end
    end

    // Read mux, evaluated every cycle independent of readEn; unmapped addresses return 0.
    always_comb begin
        dout_d = 8'h00;
        if (addr == ADDR_PAGE) dout_d = 8'(page_q);
        for (int i = 0; i < N_CFG; i++) begin
            if (addr == ADDR_CFG_BASE + 8'(i)) dout_d = cfg_q[i];
        end
        for (int k = 0; k < N_CNT; k++) begin
            if (addr == ADDR_CNT_BASE + 8'(4 * k)) dout_d = cnt_in[32*k+24 +: 8];
            for (int j = 1; j < 4; j++) begin
                if (addr == ADDR_CNT_BASE + 8'(4 * k + j)) dout_d = shadow_q[k][8*(3-j) +: 8];
            end
        end
        for (int i = 0; i < N_PULSE; i++) begin
            if (addr == ADDR_PULSE_BASE + 8'(i)) dout_d = {7'b0, pulse_out[i]};
        end
        if (addr == ADDR_VERSION) dout_d = VERSION;
    end

    // Register state and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout_q   <= 8'h00;
            page_q   <= '0;
            cfg_q    <= CFG_RESET;
            shadow_q <= '0;
            clear_q  <= '0;
            wren_q   <= 1'b0;
            wraddr_q <= '0;
        end else begin
            dout_q   <= dout_d;
            page_q   <= page_d;
            cfg_q    <= cfg_d;
            shadow_q <= shadow_d;
            clear_q  <= clear_d;
            wren_q   <= wren_d;
            wraddr_q <= wraddr_d;
        end
    end

    for (genvar g = 0; g < N_PULSE; g++) begin : g_pulse
        pulse_stretcher #(.LEN(PULSE_LEN)) u_pulse (
            .clk     (clk),
            .reset_n (reset_n),
            .trigger (pulse_trig[g]),
            .pulse   (pulse_out[g])
        );
    end

    assign dataOut       = dout_q;
    assign ram_dataIn    = dataIn;
    assign ram_wraddress = wraddr_q;
    assign ram_wren      = wren_q;
    assign cfg_data      = cfg_q;
    assign cnt_clear     = clear_q;

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Directed bench for i2c_reg_bank with hand-computed expectations.
module tb_i2c_reg_bank;

    localparam int          N_CFG     = 8;
    localparam logic [63:0] CFG_RST   = 64'h0102030405060708;
    localparam int          N_CNT     = 6;
    localparam int          N_PULSE   = 4;
    localparam int          PULSE_LEN = 4;
    localparam int          PAGE_W    = 3;
    localparam logic [7:0]  VER       = 8'hA5;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [7:0]           addr;
    logic [7:0]           dataIn;
    logic                 writeEn;
    logic                 readEn;
    logic [7:0]           dataOut;
    logic [7:0]           ram_dataIn;
    logic [PAGE_W+6:0]    ram_wraddress;
    logic                 ram_wren;
    logic [N_CFG*8-1:0]   cfg_data;
    logic [N_CNT*32-1:0]  cnt_in;
    logic [N_CNT-1:0]     cnt_clear;
    logic [N_PULSE-1:0]   pulse_out;

    int n_total = 0;
    int n_bad   = 0;

    i2c_reg_bank #(
        .N_CFG(N_CFG), .CFG_RESET(CFG_RST), .N_CNT(N_CNT), .N_PULSE(N_PULSE),
        .PULSE_LEN(PULSE_LEN), .PAGE_W(PAGE_W), .VERSION(VER)
    ) dut (
        .clk(clk), .reset_n(reset_n), .addr(addr), .dataIn(dataIn),
        .writeEn(writeEn), .readEn(readEn), .dataOut(dataOut),
        .ram_dataIn(ram_dataIn), .ram_wraddress(ram_wraddress), .ram_wren(ram_wren),
        .cfg_data(cfg_data), .cnt_in(cnt_in), .cnt_clear(cnt_clear), .pulse_out(pulse_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
        addr = a;
        tick();
        chk(tag, 64'(dataOut), 64'(exp));
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        addr    = a;
        dataIn  = d;
        writeEn = 1'b1;
        tick();
        writeEn = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        addr    = 8'h00;
        dataIn  = 8'h00;
        writeEn = 1'b0;
        readEn  = 1'b0;
        cnt_in  = '0;
        #12;
        chk("rst_dout",   64'(dataOut), 64'h0);
        chk("rst_wren",   64'(ram_wren), 64'h0);
        chk("rst_wraddr", 64'(ram_wraddress), 64'h0);
        chk("rst_clear",  64'(cnt_clear), 64'h0);
        chk("rst_pulse",  64'(pulse_out), 64'h0);
        chk("rst_cfg",    cfg_data, CFG_RST);
        @(posedge clk);
        #1 reset_n = 1'b1;

        rd("cfg0_rst", 8'h81, 8'h08);
        rd("cfg7_rst", 8'h88, 8'h01);

        // Page + OSD window write
        wr(8'h80, 8'h05);
        addr = 8'h12; dataIn = 8'hAB; writeEn = 1'b1;
        tick();
        writeEn = 1'b0;
        chk("osd_wren",   64'(ram_wren), 64'h1);
        chk("osd_wraddr", 64'(ram_wraddress), 64'h292);
        chk("osd_data",   64'(ram_dataIn), 64'hAB);
        tick();
        chk("osd_wren_1cyc", 64'(ram_wren), 64'h0);
        rd("page_rd", 8'h80, 8'h05);
        rd("osd_rd0", 8'h12, 8'h00);
        wr(8'h80, 8'hFF);
        rd("page_mask", 8'h80, 8'h07);

        // Config write
        wr(8'h83, 8'h3C);
        chk("cfg2_flat", 64'(cfg_data[23:16]), 64'h3C);
        rd("cfg2_rd", 8'h83, 8'h3C);

        // Counter snapshot coherence
        cnt_in[63:32] = 32'h11223344;
        addr = 8'hA4; readEn = 1'b1;
        tick();
        readEn = 1'b0;
        chk("cnt1_b0", 64'(dataOut), 64'h11);
        cnt_in[63:32] = 32'h55667788;
        rd("cnt1_b1", 8'hA5, 8'h22);
        rd("cnt1_b2", 8'hA6, 8'h33);
        rd("cnt1_b3", 8'hA7, 8'h44);
        rd("cnt1_live", 8'hA4, 8'h55);

        // Same-cycle byte-0 read and write: write wins
        cnt_in[31:0] = 32'hDEADBEEF;
        addr = 8'hA0; readEn = 1'b1;
        tick();
        readEn = 1'b0;
        rd("cnt0_snap", 8'hA1, 8'hAD);
        addr = 8'hA0; dataIn = 8'h00; readEn = 1'b1; writeEn = 1'b1;
        tick();
        readEn = 1'b0; writeEn = 1'b0;
        chk("clr_pulse", 64'(cnt_clear), 64'h01);
        addr = 8'hA1;
        tick();
        chk("clr_1cyc", 64'(cnt_clear), 64'h00);
        chk("clr_shadow", 64'(dataOut), 64'h00);
        wr(8'hA5, 8'hFF);
        chk("b1_wr_noclr", 64'(cnt_clear), 64'h00);
        rd("b1_wr_ignored", 8'hA5, 8'h22);

        // Pulse retrigger: writes before edges 0 and 2, high after edges 0..5
        for (int e = 0; e < 8; e++) begin
            addr    = 8'hF1;
            writeEn = (e == 0 || e == 2);
            tick();
            writeEn = 1'b0;
            chk($sformatf("pulse1_e%0d", e), 64'(pulse_out), (e <= 5) ? 64'h2 : 64'h0);
        end

        // Out-of-range pulse index
        wr(8'hF7, 8'h01);
        chk("f7_nopulse", 64'(pulse_out), 64'h0);
        rd("f7_rd", 8'hF7, 8'h00);
        wr(8'hF3, 8'h01);
        rd("f3_status", 8'hF3, 8'h01);

        // Asynchronous reset mid-pulse
        wr(8'hF0, 8'h01);
        tick();
        chk("pulse0_cyc2", 64'(pulse_out[0]), 64'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_pulse", 64'(pulse_out), 64'h0);
        chk("async_dout",  64'(dataOut), 64'h0);
        chk("async_cfg",   cfg_data, CFG_RST);
        @(posedge clk);
        #1 reset_n = 1'b1;
        rd("page_after_rst", 8'h80, 8'h00);

        rd("version", 8'hFF, VER);
        rd("unmapped_c5", 8'hC5, 8'h00);
        rd("cfg_oob_rd", 8'h89, 8'h00);
        wr(8'h89, 8'h77);
        chk("cfg_oob_wr", cfg_data, CFG_RST);
        rd("cnt_oob_rd", 8'hB8, 8'h00);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
